// File: rtl/skeleton.sv
// 5-stage pipelined 32-bit processor wrapper (F, D, X, M, W).
// Instruction ROM preloaded by the surrounding environment, data RAM written in M, results
// observed through my_regfile.register_output. Optional feature macro:
// OVF_STATUS_EN (signed overflow on add/addi/sub writes status code to r30).

module my_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] register_output [0:31]
);
  logic [31:0] regs_q [0:31];

  // Register array: cleared asynchronously, r0 is never written so it stays 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports; a W-stage write is forwarded to a same-cycle D read
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && waddr != 5'd0 && waddr == raddr1) rdata1 = wdata;
    if (we && waddr != 5'd0 && waddr == raddr2) rdata2 = wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_out
      assign register_output[gi] = regs_q[gi];
    end
  endgenerate
endmodule

module my_processor #(
  parameter int IMEM_DEPTH = 4096,
  parameter int DMEM_DEPTH = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_data,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  output logic [31:0]                   dmem_wdata,
  output logic                          dmem_we,
  input  logic [31:0]                   dmem_rdata,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic [4:0]                    rf_raddr1,
  output logic [4:0]                    rf_raddr2,
  input  logic [31:0]                   rf_rdata1,
  input  logic [31:0]                   rf_rdata2
);
  localparam int PA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {K_NOP = 3'd0, K_ALU, K_ADDI, K_SW, K_LW} kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } dx_t;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        is_lw;
    logic        is_sw;
    logic [31:0] alu;
    logic [31:0] sdata;
  } xm_t;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] data;
  } mw_t;

  logic [PA-1:0] pc_q, pc_d;
  logic [31:0]   fd_ir_q, fd_ir_d;
  dx_t           dx_q, dx_d;
  xm_t           xm_q, xm_d;
  mw_t           mw_q, mw_d;

  kind_e       d_kind;
  logic        d_use1, d_use2, hz1, hz2, stall;
  logic [4:0]  d_raddr2;
  logic [31:0] x_opb, x_sum, x_diff, x_res;
  logic        x_wr_en;
  logic [4:0]  x_wr_addr;
`ifdef OVF_STATUS_EN
  logic [1:0]  x_ovf_code;
`endif

  // D: decode source usage and detect RAW hazards against X and M destinations
  always_comb begin
    d_kind   = K_NOP;
    d_use1   = 1'b0;
    d_use2   = 1'b0;
    d_raddr2 = fd_ir_q[16:12];
    case (fd_ir_q[31:27])
      5'b00000: begin d_kind = K_ALU;  d_use1 = 1'b1; d_use2 = 1'b1; end
      5'b00101: begin d_kind = K_ADDI; d_use1 = 1'b1; end
      5'b00111: begin d_kind = K_SW;   d_use1 = 1'b1; d_use2 = 1'b1; d_raddr2 = fd_ir_q[26:22]; end
      5'b01000: begin d_kind = K_LW;   d_use1 = 1'b1; end
      default:  d_kind = K_NOP;
    endcase
    hz1 = d_use1 && fd_ir_q[21:17] != 5'd0 &&
          ((x_wr_en && x_wr_addr == fd_ir_q[21:17]) || (xm_q.wr_en && xm_q.wr_addr == fd_ir_q[21:17]));
    hz2 = d_use2 && d_raddr2 != 5'd0 &&
          ((x_wr_en && x_wr_addr == d_raddr2) || (xm_q.wr_en && xm_q.wr_addr == d_raddr2));
    stall = hz1 || hz2;
  end

  assign rf_raddr1 = fd_ir_q[21:17];
  assign rf_raddr2 = d_raddr2;

  // X: ALU and final write target (overflow may redirect the write to r30)
  always_comb begin
    x_opb     = (dx_q.kind == K_ALU) ? dx_q.b : dx_q.imm;
    x_sum     = dx_q.a + x_opb;
    x_diff    = dx_q.a - dx_q.b;
    x_res     = '0;
    x_wr_en   = 1'b0;
    x_wr_addr = dx_q.rd;
    case (dx_q.kind)
      K_ALU: begin
        x_wr_en = 1'b1;
        case (dx_q.aluop)
          5'b00000: x_res = x_sum;
          5'b00001: x_res = x_diff;
          5'b00010: x_res = dx_q.a & dx_q.b;
          5'b00011: x_res = dx_q.a | dx_q.b;
          5'b00100: x_res = dx_q.a << dx_q.shamt;
          5'b00101: x_res = $signed(dx_q.a) >>> dx_q.shamt;
          default:  x_res = '0;
        endcase
      end
      K_ADDI:  begin x_res = x_sum; x_wr_en = 1'b1; end
      K_LW:    begin x_res = x_sum; x_wr_en = 1'b1; end
      K_SW:    x_res = x_sum;
      default: x_res = '0;
    endcase
`ifdef OVF_STATUS_EN
    x_ovf_code = 2'd0;
    if (dx_q.kind == K_ALU && dx_q.aluop == 5'b00000 &&
        dx_q.a[31] == x_opb[31] && x_sum[31] != dx_q.a[31])  x_ovf_code = 2'd1;
    if (dx_q.kind == K_ADDI &&
        dx_q.a[31] == x_opb[31] && x_sum[31] != dx_q.a[31])  x_ovf_code = 2'd2;
    if (dx_q.kind == K_ALU && dx_q.aluop == 5'b00001 &&
        dx_q.a[31] != dx_q.b[31] && x_diff[31] != dx_q.a[31]) x_ovf_code = 2'd3;
    if (x_ovf_code != 2'd0) begin
      x_res     = {30'd0, x_ovf_code};
      x_wr_addr = 5'd30;
      x_wr_en   = 1'b1;
    end
`endif
    if (x_wr_addr == 5'd0) x_wr_en = 1'b0;
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = xm_q.alu[DA-1:0];
  assign dmem_wdata = xm_q.sdata;
  assign dmem_we    = xm_q.is_sw;
  assign rf_we      = mw_q.wr_en;
  assign rf_waddr   = mw_q.wr_addr;
  assign rf_wdata   = mw_q.data;

  // Next state of PC and pipeline latches; a stall holds F and bubbles D/X
  always_comb begin
    pc_d    = (pc_q == PA'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
    fd_ir_d = imem_data;
    dx_d.kind  = d_kind;
    dx_d.rd    = fd_ir_q[26:22];
    dx_d.shamt = fd_ir_q[11:7];
    dx_d.aluop = fd_ir_q[6:2];
    dx_d.imm   = {{15{fd_ir_q[16]}}, fd_ir_q[16:0]};
    dx_d.a     = rf_rdata1;
    dx_d.b     = rf_rdata2;
    if (stall) begin
      pc_d    = pc_q;
      fd_ir_d = fd_ir_q;
      dx_d    = '0;
    end
    xm_d.wr_en   = x_wr_en;
    xm_d.wr_addr = x_wr_addr;
    xm_d.is_lw   = (dx_q.kind == K_LW);
    xm_d.is_sw   = (dx_q.kind == K_SW);
    xm_d.alu     = x_res;
    xm_d.sdata   = dx_q.b;
    mw_d.wr_en   = xm_q.wr_en;
    mw_d.wr_addr = xm_q.wr_addr;
    mw_d.data    = xm_q.is_lw ? dmem_rdata : xm_q.alu;
  end

  // Pipeline state registers; reset loads PC=0 and NOPs everywhere
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      fd_ir_q <= '0;
      dx_q    <= '0;
      xm_q    <= '0;
      mw_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      fd_ir_q <= fd_ir_d;
      dx_q    <= dx_d;
      xm_q    <= xm_d;
      mw_q    <= mw_d;
    end
  end
endmodule

module skeleton #(
  parameter string IMEM_FILE  = "imem.hex",
  parameter int    IMEM_DEPTH = 4096,
  parameter int    DMEM_DEPTH = 4096
) (
  input logic clock,
  input logic reset
);
  localparam int PA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  logic [31:0]   imem [0:IMEM_DEPTH-1];
  logic [31:0]   dmem [0:DMEM_DEPTH-1];
  logic [PA-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [DA-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          dmem_we;
  logic          rf_we;
  logic [4:0]    rf_waddr, rf_raddr1, rf_raddr2;
  logic [31:0]   rf_wdata, rf_rdata1, rf_rdata2;
  logic [31:0]   register_output [0:31];

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  // Data RAM write port; blocked while reset is held
  always_ff @(posedge clock) begin
    if (reset && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  my_processor #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) my_processor (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  my_regfile my_regfile (
    .clock(clock), .reset(reset),
    .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr1(rf_raddr1), .raddr2(rf_raddr2), .rdata1(rf_rdata1), .rdata2(rf_rdata2),
    .register_output(register_output)
  );
endmodule

// File: tb/tb_skeleton.sv
// Directed-program bench for skeleton: loads small programs into the ROM,
// runs them and compares register/memory contents with hand-computed values.
module tb_skeleton;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  skeleton #(.IMEM_FILE(""), .IMEM_DEPTH(4096), .DMEM_DEPTH(4096)) dut (
    .clock(clock),
    .reset(reset)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] aluop, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] shamt);
    return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] rg(input int i);
    return dut.my_regfile.register_output[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    $display("check %s: got %h expected %h", tag, got, exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int nz;

    // 1: addi $30,$0,5 -- reset state, exact latency, final state
    clear_imem();
    dut.imem[0] = enc_i(5'b00101, 5'd30, 5'd0, 17'd5);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_pc", 32'(dut.my_processor.pc_q), 32'h0);
    check("reset_fd_nop", dut.my_processor.fd_ir_q, 32'h0);
    reset = 1'b1;
    step(4);
    check("t1_r30_before_edge5", rg(30), 32'h0);
    step(1);
    check("t1_r30_at_edge5", rg(30), 32'h5);
    step(6);
    nz = 0;
    for (int i = 0; i < 32; i++) if (i != 30 && rg(i) != 32'h0) nz++;
    check("t1_other_regs_nonzero", 32'(nz), 32'h0);
    check("t1_r30_final", rg(30), 32'h5);

    // 2: dependent chain, two bubbles per dependency
    clear_imem();
    dut.imem[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'd7);
    dut.imem[1] = enc_i(5'b00101, 5'd2, 5'd1, 17'd3);
    dut.imem[2] = enc_r(5'b00001, 5'd3, 5'd2, 5'd1, 5'd0);
    do_reset();
    step(7);
    check("t2_r2_before_edge8", rg(2), 32'h0);
    step(1);
    check("t2_r2_at_edge8", rg(2), 32'd10);
    check("t2_r1", rg(1), 32'd7);
    step(2);
    check("t2_r3_before_edge11", rg(3), 32'h0);
    step(1);
    check("t2_r3_at_edge11", rg(3), 32'd3);

    // 3: shifts, logic ops, unused aluop writes 0
    clear_imem();
    dut.imem[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'h1FFFC);
    dut.imem[1] = enc_r(5'b00101, 5'd2, 5'd1, 5'd0, 5'd1);
    dut.imem[2] = enc_r(5'b00100, 5'd3, 5'd1, 5'd0, 5'd2);
    dut.imem[3] = enc_i(5'b00101, 5'd7, 5'd0, 17'd1);
    dut.imem[4] = enc_r(5'b00111, 5'd7, 5'd0, 5'd0, 5'd0);
    dut.imem[5] = enc_r(5'b00011, 5'd9, 5'd2, 5'd3, 5'd0);
    dut.imem[6] = enc_r(5'b00010, 5'd10, 5'd1, 5'd3, 5'd0);
    do_reset();
    step(40);
    check("t3_r1", rg(1), 32'hFFFFFFFC);
    check("t3_sra_r2", rg(2), 32'hFFFFFFFE);
    check("t3_sll_r3", rg(3), 32'hFFFFFFF0);
    check("t3_unused_aluop_r7", rg(7), 32'h0);
    check("t3_or_r9", rg(9), 32'hFFFFFFFE);
    check("t3_and_r10", rg(10), 32'hFFFFFFF0);

    // 4: store/load round trip, r0 write ignored, load-use hazard
    clear_imem();
    dut.imem[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'd9);
    dut.imem[1] = enc_i(5'b00111, 5'd1, 5'd0, 17'd3);
    dut.imem[2] = enc_i(5'b01000, 5'd4, 5'd0, 17'd3);
    dut.imem[3] = enc_i(5'b00101, 5'd0, 5'd0, 17'd5);
    dut.imem[4] = enc_i(5'b00101, 5'd5, 5'd4, 17'd1);
    do_reset();
    step(30);
    check("t4_dmem3", dut.dmem[3], 32'd9);
    check("t4_lw_r4", rg(4), 32'd9);
    check("t4_r0", rg(0), 32'h0);
    check("t4_load_use_r5", rg(5), 32'd10);

    // 5: signed overflow on add
    clear_imem();
    dut.imem[0] = enc_i(5'b00101, 5'd2, 5'd0, 17'd1);
    dut.imem[1] = enc_r(5'b00100, 5'd2, 5'd2, 5'd0, 5'd31);
    dut.imem[2] = enc_i(5'b00101, 5'd1, 5'd0, 17'h1FFFF);
    dut.imem[3] = enc_r(5'b00001, 5'd1, 5'd1, 5'd2, 5'd0);
    dut.imem[4] = enc_r(5'b00000, 5'd5, 5'd1, 5'd1, 5'd0);
    dut.imem[5] = enc_r(5'b00000, 5'd6, 5'd1, 5'd0, 5'd0);
    do_reset();
    step(40);
    check("t5_r2", rg(2), 32'h80000000);
    check("t5_r1", rg(1), 32'h7FFFFFFF);
    check("t5_r6", rg(6), 32'h7FFFFFFF);
`ifdef OVF_STATUS_EN
    check("t5_ovf_r5", rg(5), 32'h0);
    check("t5_ovf_r30", rg(30), 32'h1);
`else
    check("t5_wrap_r5", rg(5), 32'hFFFFFFFE);
    check("t5_r30", rg(30), 32'h0);
`endif

    // 6: asynchronous reset mid-program, then re-run
    do_reset();
    step(12);
    check("t6_r2_midrun", rg(2), 32'h80000000);
    #2 reset = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (rg(i) != 32'h0) nz++;
    check("t6_async_regs_nonzero", 32'(nz), 32'h0);
    check("t6_async_pc", 32'(dut.my_processor.pc_q), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step(40);
    check("t6_rerun_r1", rg(1), 32'h7FFFFFFF);
`ifdef OVF_STATUS_EN
    check("t6_rerun_r30", rg(30), 32'h1);
`else
    check("t6_rerun_r5", rg(5), 32'hFFFFFFFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
